demux_sched: RTL

Round-robin scheduler that shares the 1x8 demultiplexer's single data path among eight requesters. It arbitrates per-channel requests and drives the demux `sel` and active-low `den`, holding each grant for a programmable burst. Non-preemptive, and `sel` never changes while `den` is active. It sits between the channel request logic and the 1x8 demux instance.

---
 rtl/demux_sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/demux_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg
// Shared types and constants for the 1x8 demux scheduler.
//   sched_state_t : scheduler FSM states
//   NUM_CH        : channel count (fixed by the 3-bit demux select)
//   SEL_W         : demux select width
//   DEN_ACTIVE    : level of den that enables the selected demux output
//   onehot()      : converts a channel index to a one-hot channel vector
package demux_sched_pkg;

   localparam int   NUM_CH     = 8;
   localparam int   SEL_W      = 3;
   localparam logic DEN_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BURST,
      RELEASE
   } sched_state_t;

   function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_CH-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The request vector is viewed rotated so
// that the channel after 'last' has highest priority; the first set bit in
// that rotated view is the winner, reported back as an absolute index.
//   req  : per-channel request vector
//   last : index of the most recently served channel
//   win  : index of the winning channel (0 when no request)
//   any  : at least one request is present
module rr_arbiter
   import demux_sched_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  last,
   output logic [SEL_W-1:0]  win,
   output logic              any
);

   logic [SEL_W-1:0] idx;

   // Walk the rotated positions from lowest priority to highest so the
   // highest-priority requester is the last one to overwrite the result.
   // The 3-bit index arithmetic wraps naturally, which performs the
   // rotate and unrotate in one step.
   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = last + 3'd1 + 3'(i);
         if (req[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_sched.sv
// demux_sched
// Round-robin scheduler sharing a 1x8 demux data path among eight requesters.
// Each grant is held for a programmable, non-preemptible burst; sel only
// changes while den is inactive so every enabled window has a stable select.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-channel level requests
//   burst_len : burst length minus one, sampled in GRANT
//   sel       : demux select (registered)
//   den       : demux enable, active low (registered)
//   grant     : one-hot grant (registered)
//   busy      : scheduler is not idle
//   done      : one-cycle pulse when a burst is released
module demux_sched #(
   parameter int NUM_CH  = 8,
   parameter int BURST_W = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             req,
   input  logic [BURST_W-1:0]            burst_len,
   output logic [demux_sched_pkg::SEL_W-1:0] sel,
   output logic                          den,
   output logic [NUM_CH-1:0]             grant,
   output logic                          busy,
   output logic                          done
);

   import demux_sched_pkg::*;

   sched_state_t       state;
   logic [SEL_W-1:0]   last;
   logic [SEL_W-1:0]   winner;
   logic [BURST_W-1:0] cnt;

   logic [SEL_W-1:0]   arb_last;
   logic [SEL_W-1:0]   arb_win;
   logic               arb_any;

   // In RELEASE the pointer register is being updated on this same edge,
   // so the arbiter must already see the channel just served.
   assign arb_last = (state == RELEASE) ? winner : last;

   rr_arbiter u_arb (
      .req  (req),
      .last (arb_last),
      .win  (arb_win),
      .any  (arb_any)
   );

   assign busy = (state != IDLE);

   // Scheduler FSM with registered outputs. Each state's branch drives the
   // outputs that become visible on the following cycle: GRANT loads the
   // select and grant while den stays inactive, BURST holds den active for
   // burst_len+1 cycles, RELEASE drops den and grant and pulses done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last   <= 3'd7;
         winner <= '0;
         cnt    <= '0;
         sel    <= '0;
         den    <= ~DEN_ACTIVE;
         grant  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  winner <= arb_win;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               sel   <= winner;
               grant <= onehot(winner);
               den   <= ~DEN_ACTIVE;
               cnt   <= burst_len;
               state <= BURST;
            end
            BURST: begin
               den <= DEN_ACTIVE;
               if (cnt == '0) begin
                  state <= RELEASE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RELEASE: begin
               den   <= ~DEN_ACTIVE;
               grant <= '0;
               done  <= 1'b1;
               last  <= winner;
               if (arb_any) begin
                  winner <= arb_win;
                  state  <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
